scale_register: RTL and testbench
=================================

SCALE_REGISTER -- requirements
Module: scale_register

Interface
REQ-001 Parameter PW, default 8, price (cost) width in bits.
REQ-002 Parameter QW, default 4, quantity width in bits.
REQ-003 Parameter SW, default 16, running-sum / result width in bits; SW SHALL be >= PW+QW.
REQ-004 Parameter MAX_ITEMS, default 15, maximum accepted line items per transaction; CW = clog2(MAX_ITEMS+1).
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 enter  input  1  one-cycle request to add a line item (cost x qty).
REQ-008 cost  input  PW  unit price, sampled when enter is accepted.
REQ-009 qty  input  QW  quantity, sampled when enter is accepted.
REQ-010 total  input  1  one-cycle request to publish the running sum.
REQ-011 clear  input  1  one-cycle request to start a new transaction.
REQ-012 result  output  SW  last published sum, held until the next total or clear.
REQ-013 result_valid  output  1  one-cycle pulse when result is updated by total.
REQ-014 busy  output  1  high while a line item is being processed.
REQ-015 item_count  output  CW  number of accepted line items this transaction.
REQ-016 item_rejected  output  1  one-cycle pulse when an enter is refused.
REQ-017 overflow  output  1  sticky; set when the sum saturates.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, MUL, ACC; reset state IDLE.
REQ-019 enter, total and clear SHALL be acted on only in IDLE; in other states they are ignored, with no pulse and no queuing.
REQ-020 Priority in IDLE, for simultaneous requests: clear > total > enter; lower-priority requests in the same cycle are dropped.
REQ-021 clear SHALL zero the sum, item_count, overflow and result in the next cycle, with no result_valid pulse.
REQ-022 total SHALL copy the sum to result and pulse result_valid in the next cycle; the sum and item_count are unchanged.
REQ-023 enter with qty==0 or item_count==MAX_ITEMS SHALL be refused: item_rejected pulses next cycle, state stays IDLE.
REQ-024 An accepted enter SHALL latch cost and qty and go IDLE->LOAD; then LOAD->MUL.
REQ-025 MUL SHALL compute the PW+QW-bit product by shift-add, one qty bit per cycle, for exactly QW cycles, then go to ACC.
REQ-026 In ACC, if sum+product > 2^SW-1: sum becomes 2^SW-1 and overflow is set; otherwise sum += product. Then item_count increments and the FSM returns to IDLE.
REQ-027 busy SHALL be high in LOAD, MUL and ACC: QW+2 cycles, starting the cycle after enter is accepted.
REQ-028 Once overflow is set, further items SHALL still be accepted and counted, and the sum SHALL stay saturated.
REQ-029 item_count SHALL never exceed MAX_ITEMS; there is no wrap-around.

Reset
REQ-030 With reset low at a clock edge: state IDLE; result, sum, item_count, product and latched operands zero; result_valid, busy, item_rejected and overflow low.
REQ-031 Reset mid-operation SHALL abort the item without adding it, and the next cycle SHALL be IDLE.

Structure
REQ-032 The FSM state encoding and the parameter defaults SHALL live in the shared package scale_pkg.
REQ-033 The shift-add multiplier SHALL be the sub-module seq_mult, with start/done handshake, parameters PW and QW, and a fixed QW-cycle latency.

Verification (defaults unless stated)
REQ-034 Reset, then enter cost=25 qty=3, then enter cost=10 qty=4, then total -> result=115, result_valid one pulse, item_count=2.
REQ-035 enter cost=7 qty=2, then enter asserted on every busy cycle -> only one item is added; busy lasts exactly 6 cycles; total gives 14.
REQ-036 SW=12: two enters cost=255 qty=15 -> sum saturates at 4095, overflow=1; clear -> sum=0, overflow=0, item_count=0.
REQ-037 15 accepted items, then a 16th enter -> item_rejected pulse, item_count stays 15; separately, enter with qty=0 -> item_rejected, item_count unchanged.
REQ-038 clear, total and enter in the same IDLE cycle -> clear wins; result=0, no result_valid, no item added.
REQ-039 reset driven low during MUL of cost=9 qty=9 -> next cycle IDLE, busy=0, sum=0; total afterwards gives 0.

Source files
------------

// File: rtl/scale_pkg.sv
// Shared definitions for the scale register: parameter defaults and the
// controller state encoding.
package scale_pkg;

    localparam int DEF_PW        = 8;
    localparam int DEF_QW        = 4;
    localparam int DEF_SW        = 16;
    localparam int DEF_MAX_ITEMS = 15;

    typedef logic [1:0] state_t;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_ACC  = 2'd3;

endpackage

// File: rtl/seq_mult.sv
// Shift-add multiplier: consumes one multiplier bit per cycle, fixed QW-cycle latency.
module seq_mult
    import scale_pkg::*;
#(
    parameter int PW = DEF_PW,
    parameter int QW = DEF_QW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [PW-1:0]    mcand_i,
    input  logic [QW-1:0]    mplier_i,
    output logic             done_o,
    output logic [PW+QW-1:0] product_o
);

    localparam int CNTW = $clog2(QW + 1);

    logic [PW+QW-1:0] mcand_q, mcand_d;
    logic [PW+QW-1:0] prod_q, prod_d;
    logic [QW-1:0]    mplier_q, mplier_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    // Handshake: start_i is a one-cycle pulse that loads the operands; QW step
    // cycles follow and done_o is high during the last one, so product_o is
    // valid from the following cycle until the next start_i.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            mcand_d  = {{QW{1'b0}}, mcand_i};
            mplier_d = mplier_i;
            prod_d   = '0;
            cnt_d    = CNTW'(QW);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign done_o    = (cnt_q == CNTW'(1));
    assign product_o = prod_q;

endmodule

// File: rtl/scale_register.sv
// Cash-register style accumulator: sums cost x qty line items with saturation,
// publishes the sum on request and tracks the number of items per transaction.
module scale_register
    import scale_pkg::*;
#(
    parameter int PW        = DEF_PW,
    parameter int QW        = DEF_QW,
    parameter int SW        = DEF_SW,
    parameter int MAX_ITEMS = DEF_MAX_ITEMS,
    localparam int CW       = $clog2(MAX_ITEMS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enter,
    input  logic [PW-1:0] cost,
    input  logic [QW-1:0] qty,
    input  logic          total,
    input  logic          clear,
    output logic [SW-1:0] result,
    output logic          result_valid,
    output logic          busy,
    output logic [CW-1:0] item_count,
    output logic          item_rejected,
    output logic          overflow,
    output state_t        state_o
);

    localparam int SUMW = SW + 1;

    state_t        state_q, state_d;
    logic [PW-1:0] cost_q, cost_d;
    logic [QW-1:0] qty_q, qty_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [SW-1:0] result_q, result_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          rv_q, rv_d;
    logic          rej_q, rej_d;

    logic             mult_start;
    logic             mult_done;
    logic [PW+QW-1:0] mult_product;
    logic [SW:0]      sum_ext;

    seq_mult #(
        .PW (PW),
        .QW (QW)
    ) u_mult (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mult_start),
        .mcand_i   (cost_q),
        .mplier_i  (qty_q),
        .done_o    (mult_done),
        .product_o (mult_product)
    );

    always_comb begin
        state_d    = state_q;
        cost_d     = cost_q;
        qty_d      = qty_q;
        sum_d      = sum_q;
        result_d   = result_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        rv_d       = 1'b0;
        rej_d      = 1'b0;
        mult_start = 1'b0;
        // One extra bit exposes the carry out, which is the saturation trigger.
        sum_ext    = {1'b0, sum_q} + SUMW'(mult_product);

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    sum_d    = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                    result_d = '0;
                end else if (total) begin
                    result_d = sum_q;
                    rv_d     = 1'b1;
                end else if (enter) begin
                    if (qty == '0 || count_q == CW'(MAX_ITEMS)) begin
                        rej_d = 1'b1;
                    end else begin
                        cost_d  = cost;
                        qty_d   = qty;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                mult_start = 1'b1;
                state_d    = S_MUL;
            end
            S_MUL: begin
                if (mult_done) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (sum_ext[SW]) begin
                    sum_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    sum_d = sum_ext[SW-1:0];
                end
                count_d = count_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cost_q   <= '0;
            qty_q    <= '0;
            sum_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rv_q     <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cost_q   <= cost_d;
            qty_q    <= qty_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rv_q     <= rv_d;
            rej_q    <= rej_d;
        end
    end

    assign result        = result_q;
    assign result_valid  = rv_q;
    assign busy          = (state_q != S_IDLE);
    assign item_count    = count_q;
    assign item_rejected = rej_q;
    assign overflow      = ovf_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_scale_register.sv
// Directed bench for scale_register: default instance plus an SW=12 instance
// sharing the same stimulus for the saturation scenario.
module tb_scale_register;
    import scale_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enter;
    logic [7:0]  cost;
    logic [3:0]  qty;
    logic        total;
    logic        clear;

    logic [15:0] result;
    logic        result_valid, busy, item_rejected, overflow;
    logic [3:0]  item_count;
    state_t      state;

    logic [11:0] result12;
    logic        result_valid12, busy12, item_rejected12, overflow12;
    logic [3:0]  item_count12;
    state_t      state12;

    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          model_sum;
    int          busy_cycles;
    bit          rej_seen;

    always #5 clk = ~clk;

    scale_register dut (
        .clk           (clk),
        .reset         (reset),
        .enter         (enter),
        .cost          (cost),
        .qty           (qty),
        .total         (total),
        .clear         (clear),
        .result        (result),
        .result_valid  (result_valid),
        .busy          (busy),
        .item_count    (item_count),
        .item_rejected (item_rejected),
        .overflow      (overflow),
        .state_o       (state)
    );

    scale_register #(.SW(12)) dut12 (
        .clk           (clk),
        .reset         (reset),
        .enter         (enter),
        .cost          (cost),
        .qty           (qty),
        .total         (total),
        .clear         (clear),
        .result        (result12),
        .result_valid  (result_valid12),
        .busy          (busy12),
        .item_count    (item_count12),
        .item_rejected (item_rejected12),
        .overflow      (overflow12),
        .state_o       (state12)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every clock advance also acts as the result monitor for the default instance.
    task automatic tick();
        logic [15:0] e;
        @(posedge clk);
        #1;
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard_result", 32'(result), 32'(e));
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_enter(input logic [7:0] c, input logic [3:0] q);
        enter = 1'b1;
        cost  = c;
        qty   = q;
        tick();
        enter = 1'b0;
    endtask

    task automatic do_item(input logic [7:0] c, input logic [3:0] q);
        do_enter(c, q);
        wait_idle();
    endtask

    task automatic do_total(input logic [15:0] e);
        exp_q.push_back(e);
        total = 1'b1;
        tick();
        total = 1'b0;
        check("total_result_valid", 32'(result_valid), 32'd1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        enter = 1'b0;
        cost  = '0;
        qty   = '0;
        total = 1'b0;
        clear = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_result", 32'(result), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_item_count", 32'(item_count), 32'd0);
        check("rst_item_rejected", 32'(item_rejected), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_state", 32'(state), 32'(S_IDLE));
        reset = 1'b1;
        tick();

        // Two items then total
        do_item(8'd25, 4'd3);
        do_item(8'd10, 4'd4);
        do_total(16'd115);
        check("basic_item_count", 32'(item_count), 32'd2);
        tick();
        check("basic_rv_single_pulse", 32'(result_valid), 32'd0);
        check("basic_result_held", 32'(result), 32'd115);

        // Enter held through the busy window, operands changing underneath
        do_clear();
        enter = 1'b1;
        cost  = 8'd7;
        qty   = 4'd2;
        busy_cycles = 0;
        rej_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            cost = 8'd99;
            qty  = 4'd5;
            if (item_rejected) rej_seen = 1'b1;
            if (!busy) break;
            busy_cycles++;
        end
        enter = 1'b0;
        check("busy_cycle_count", 32'(busy_cycles), 32'd6);
        check("busy_no_reject", 32'(rej_seen), 32'd0);
        check("busy_item_count", 32'(item_count), 32'd1);
        do_total(16'd14);

        // Saturation on the SW=12 instance; default instance stays exact
        reset = 1'b0;
        tick();
        reset = 1'b1;
        do_item(8'd255, 4'd15);
        check("sat_first_no_ovf", 32'(overflow12), 32'd0);
        do_item(8'd255, 4'd15);
        check("sat_overflow12", 32'(overflow12), 32'd1);
        check("sat_overflow16", 32'(overflow), 32'd0);
        check("sat_item_count12", 32'(item_count12), 32'd2);
        do_total(16'd7650);
        check("sat_result12", 32'(result12), 32'd4095);
        check("sat_result_valid12", 32'(result_valid12), 32'd1);
        do_clear();
        check("clr_overflow12", 32'(overflow12), 32'd0);
        check("clr_item_count12", 32'(item_count12), 32'd0);
        check("clr_result12", 32'(result12), 32'd0);
        do_total(16'd0);
        check("clr_sum12", 32'(result12), 32'd0);

        // Fill to the item limit with random items
        do_clear();
        model_sum = 0;
        for (int i = 0; i < 15; i++) begin
            logic [7:0] c;
            logic [3:0] q;
            c = 8'($urandom_range(0, 255));
            q = 4'($urandom_range(1, 15));
            model_sum += int'(c) * int'(q);
            do_item(c, q);
        end
        check("full_item_count", 32'(item_count), 32'd15);
        do_enter(8'd3, 4'd2);
        check("full_reject_pulse", 32'(item_rejected), 32'd1);
        check("full_reject_idle", 32'(busy), 32'd0);
        tick();
        check("full_reject_one_cycle", 32'(item_rejected), 32'd0);
        check("full_item_count_held", 32'(item_count), 32'd15);
        do_total(16'(model_sum));

        // qty == 0 is refused
        do_clear();
        do_item(8'd5, 4'd3);
        do_enter(8'd5, 4'd0);
        check("qty0_reject_pulse", 32'(item_rejected), 32'd1);
        check("qty0_busy", 32'(busy), 32'd0);
        check("qty0_item_count", 32'(item_count), 32'd1);
        do_total(16'd15);

        // clear beats total and enter in the same cycle
        clear = 1'b1;
        total = 1'b1;
        enter = 1'b1;
        cost  = 8'd4;
        qty   = 4'd4;
        tick();
        clear = 1'b0;
        total = 1'b0;
        enter = 1'b0;
        check("prio_no_result_valid", 32'(result_valid), 32'd0);
        check("prio_result", 32'(result), 32'd0);
        check("prio_busy", 32'(busy), 32'd0);
        check("prio_item_count", 32'(item_count), 32'd0);

        // Reset in the middle of a multiply
        do_enter(8'd9, 4'd9);
        tick();
        tick();
        check("abort_in_mul", 32'(state), 32'(S_MUL));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_state", 32'(state), 32'(S_IDLE));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_item_count", 32'(item_count), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("abort_stays_idle", 32'(busy), 32'd0);
        do_total(16'd0);

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
